// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, filters lock, then releases reset lines in order.
// Optional lock-loss event counter is built only when PLL_LOSS_CNT_EN is defined.
module pll_lock_supervisor #(
  parameter int NUM_OUT      = 3,
  parameter int RST_PULSE    = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_FILT    = 256,
  parameter int SEQ_GAP      = 8,
  parameter int MAX_RETRY    = 4
) (
  input  logic               clkin1,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               soft_rst,
  output logic               pll_rst,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               locked_ok,
  output logic               fail,
  output logic [3:0]         retry_cnt,
  output logic [7:0]         loss_cnt
);

  localparam int REL_SPAN = (NUM_OUT - 1) * SEQ_GAP;
  localparam int M1 = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int M2 = (M1 > LOCK_FILT) ? M1 : LOCK_FILT;
  localparam int M3 = (M2 > REL_SPAN) ? M2 : REL_SPAN;
  localparam int CW = $clog2(M3) + 1;

  localparam logic [2:0] S_RST_PLS   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_FILTER    = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;
  localparam logic [2:0] S_FAIL      = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;     // pulse / filter / release counter, one user at a time
  logic [CW-1:0]      tmo_q, tmo_d;
  logic [3:0]         retry_q, retry_d;
  logic [NUM_OUT-1:0] rst_out_n_q, rst_out_n_d;
  logic               pll_rst_q, pll_rst_d;
  logic               locked_ok_q, locked_ok_d;
  logic               fail_q, fail_d;
  logic               lock_meta_q, lock_s_q;
  logic               lost, tmo_hit;

  always_ff @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    lost    = (state_q == S_RELEASE || state_q == S_RUN) && !lock_s_q;
    tmo_hit = (state_q == S_WAIT_LOCK || state_q == S_FILTER) &&
              (tmo_q == CW'(LOCK_TIMEOUT - 1));
    if (soft_rst) begin
      state_d = S_RST_PLS;
      cnt_d   = '0;
      retry_d = '0;
    end else if (lost) begin
      state_d = S_RST_PLS;
      cnt_d   = '0;
    end else if (tmo_hit) begin
      retry_d = retry_q + 4'd1;
      state_d = (retry_d == 4'(MAX_RETRY)) ? S_FAIL : S_RST_PLS;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_RST_PLS: begin
          if (cnt_q == CW'(RST_PULSE - 1)) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          tmo_d = tmo_q + 1'b1;
          if (lock_s_q) begin
            state_d = S_FILTER;
            cnt_d   = '0;
          end
        end
        S_FILTER: begin
          // timeout keeps running across filter restarts
          tmo_d = tmo_q + 1'b1;
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == CW'(LOCK_FILT - 1)) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RELEASE: begin
          if (cnt_q == CW'(REL_SPAN)) begin
            state_d = S_RUN;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    rst_out_n_d = '0;
    if (state_d == S_RELEASE || state_d == S_RUN) begin
      for (int i = 0; i < NUM_OUT; i++)
        rst_out_n_d[i] = rst_out_n_q[i] | (cnt_d == CW'(i * SEQ_GAP));
    end
    pll_rst_d   = (state_d == S_RST_PLS) || (state_d == S_FAIL);
    locked_ok_d = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  always_ff @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST_PLS;
      cnt_q       <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      rst_out_n_q <= '0;
      pll_rst_q   <= 1'b1;
      locked_ok_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      rst_out_n_q <= rst_out_n_d;
      pll_rst_q   <= pll_rst_d;
      locked_ok_q <= locked_ok_d;
      fail_q      <= fail_d;
    end
  end

`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  // saturating; survives soft_rst
  always_comb begin
    loss_d = loss_q;
    if (lost && loss_q != 8'hFF) loss_d = loss_q + 8'd1;
  end

  always_ff @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) loss_q <= '0;
    else        loss_q <= loss_d;
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'd0;
`endif

  assign pll_rst   = pll_rst_q;
  assign rst_out_n = rst_out_n_q;
  assign locked_ok = locked_ok_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor at default parameters; cycle numbers are hand-derived.
module tb_pll_lock_supervisor;

  logic       clkin1 = 1'b0;
  logic       rst_n, pll_lock, soft_rst;
  logic       pll_rst, locked_ok, fail;
  logic [2:0] rst_out_n;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

`ifdef PLL_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  pll_lock_supervisor dut (
    .clkin1    (clkin1),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .soft_rst  (soft_rst),
    .pll_rst   (pll_rst),
    .rst_out_n (rst_out_n),
    .locked_ok (locked_ok),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  always #5 clkin1 = ~clkin1;
  always @(posedge clkin1) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin1);
    #1;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return pll_rst;
      1:       return rst_out_n[0];
      2:       return rst_out_n[1];
      3:       return rst_out_n[2];
      4:       return locked_ok;
      default: return fail;
    endcase
  endfunction

  // returns the absolute cycle where sig(w)==v, or -1 if the bound expires
  task automatic wait_sig(input int w, input logic v, input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      if (sig(w) == v) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int b, t, tf, tr, f, rise_ref;
    rst_n = 1'b0; pll_lock = 1'b1; soft_rst = 1'b0;
    repeat (3) @(posedge clkin1);
    #1;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_rst_out", rst_out_n, 0);
    check("rst_locked", locked_ok, 0);
    check("rst_fail", fail, 0);
    check("rst_retry", retry_cnt, 0);
    check("rst_loss", loss_cnt, 0);

    // normal bring-up with lock held high
    rst_n = 1'b1; b = cyc;
    wait_sig(0, 1'b0, 100, t); check("up_pls_fall", t - b, 16);
    wait_sig(1, 1'b1, 400, t); check("up_rel0", t - b, 273);
    wait_sig(2, 1'b1, 50, t);  check("up_rel1", t - b, 281);
    wait_sig(3, 1'b1, 50, t);  check("up_rel2", t - b, 289);
    wait_sig(4, 1'b1, 10, t);  check("up_run", t - b, 290);
    check("up_rst_out", rst_out_n, 7);
    check("up_pll_rst", pll_rst, 0);

    // one-cycle lock drop in RUN
    repeat (5) tick();
    pll_lock = 1'b0; tick(); pll_lock = 1'b1; tick(); tick();
    check("loss_rst_out", rst_out_n, 0);
    check("loss_locked", locked_ok, 0);
    check("loss_pll_rst", pll_rst, 1);
    check("loss_cnt1", loss_cnt, LOSS_EN);
    b = cyc;
    wait_sig(4, 1'b1, 400, t); check("loss_rerun", t - b, 290);

    // soft_rst in the cycle lock_s falls
    repeat (5) tick();
    pll_lock = 1'b0; tick(); pll_lock = 1'b1; tick();
    soft_rst = 1'b1; tick(); soft_rst = 1'b0; b = cyc;
    check("sl_pll_rst", pll_rst, 1);
    check("sl_locked", locked_ok, 0);
    check("sl_retry", retry_cnt, 0);
    check("sl_loss", loss_cnt, 2 * LOSS_EN);
    wait_sig(0, 1'b0, 40, t); check("sl_pulse_len", t - b, 16);

    // async reset in the middle of RELEASE
    wait_sig(2, 1'b1, 400, t); check("mid_rel1", t - b, 281);
    check("mid_rst_out", rst_out_n, 3);
    #3 rst_n = 1'b0;
    #1;
    check("arst_rst_out", rst_out_n, 0);
    check("arst_pll_rst", pll_rst, 1);
    check("arst_retry", retry_cnt, 0);
    check("arst_loss", loss_cnt, 0);
    check("arst_locked", locked_ok, 0);

    // lock never arrives: four timeouts then FAIL
    pll_lock = 1'b0;
    repeat (3) @(posedge clkin1);
    #1;
    rst_n = 1'b1; b = cyc; rise_ref = b;
    for (int r = 1; r <= 4; r++) begin
      wait_sig(0, 1'b0, 100, tf);  check("to_pulse_len", tf - rise_ref, 16);
      wait_sig(0, 1'b1, 4200, tr); check("to_gap", tr - tf, 4096);
      check("to_retry", retry_cnt, r);
      check("to_fail", fail, (r == 4) ? 1 : 0);
      rise_ref = tr;
    end
    repeat (40) tick();
    check("fail_hold_pll_rst", pll_rst, 1);
    check("fail_hold", fail, 1);
    check("fail_rst_out", rst_out_n, 0);
    soft_rst = 1'b1; tick(); soft_rst = 1'b0; b = cyc;
    check("sr_fail", fail, 0);
    check("sr_retry", retry_cnt, 0);
    check("sr_pll_rst", pll_rst, 1);
    wait_sig(0, 1'b0, 40, t); check("sr_pulse_len", t - b, 16);
    f = t;

    // filter glitch at filter count 200
    pll_lock = 1'b1;
    while (cyc < f + 201) tick();
    pll_lock = 1'b0; tick(); pll_lock = 1'b1;
    wait_sig(1, 1'b1, 600, t); check("glitch_rel0", t - f, 461);
    check("glitch_retry", retry_cnt, 0);

    // lock arrives too late: timeout expires inside FILTER
    pll_lock = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1; b = cyc;
    wait_sig(0, 1'b0, 40, t); check("late_pls_fall", t - b, 16);
    f = t;
    while (cyc < f + 3900) tick();
    pll_lock = 1'b1;
    wait_sig(0, 1'b1, 400, t); check("late_timeout", t - f, 4096);
    check("late_retry", retry_cnt, 1);
    check("late_rst_out", rst_out_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
